// File: rtl/handshake_pkg.sv
// Shared types for the clocked four-phase fork: FSM state encoding and default depths.
package handshake_pkg;

    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        RET  = 2'd3
    } fork_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-bit, multi-stage flop synchronizer with asynchronous active-low clear.
module sync_ff #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/fork_param_sync.sv
// Clocked parametric fork: one upstream four-phase request fanned out to `size`
// branches, with a single acknowledge once every enabled branch has acknowledged.
module fork_param_sync
    import handshake_pkg::*;
#(
    parameter int unsigned size        = 2,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_up,
    output logic             ack_up,
    output logic [size-1:0]  req_dn,
    input  logic [size-1:0]  ack_dn,
    input  logic [size-1:0]  mask,
    output logic             timeout_err,
    output logic [CNT_W-1:0] txn_count
);

    localparam int unsigned WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    // Reset asserts asynchronously but releases only after two clean edges.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    logic            req_s;
    logic [size-1:0] ack_s;

    sync_ff #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_sync_req (
        .clk   (clk),
        .rst_n (rst_n_int),
        .d_i   (req_up),
        .q_o   (req_s)
    );

    sync_ff #(
        .WIDTH  (size),
        .STAGES (SYNC_STAGES)
    ) u_sync_ack (
        .clk   (clk),
        .rst_n (rst_n_int),
        .d_i   (ack_dn),
        .q_o   (ack_s)
    );

    fork_state_t      state_q, state_d;
    logic [size-1:0]  mask_q, mask_d;
    logic [size-1:0]  req_dn_q, req_dn_d;
    logic             ack_up_q, ack_up_d;
    logic [CNT_W-1:0] txn_q, txn_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             terr_q, terr_d;
    logic             in_wait_q, in_wait_d;

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            req_dn_q <= '0;
            ack_up_q <= 1'b0;
            txn_q    <= '0;
            wd_q     <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            req_dn_q <= req_dn_d;
            ack_up_q <= ack_up_d;
            txn_q    <= txn_d;
            wd_q     <= wd_d;
            terr_q   <= terr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        req_dn_d = req_dn_q;
        ack_up_d = ack_up_q;
        txn_d    = txn_q;
        wd_d     = '0;
        terr_d   = terr_q;

        case (state_q)
            IDLE: begin
                req_dn_d = '0;
                ack_up_d = 1'b0;
                // Stale acks on enabled branches must clear before a new request.
                if (req_s && ((ack_s & mask) == '0)) begin
                    state_d  = REQ;
                    mask_d   = mask;
                    req_dn_d = mask;
                end
            end
            REQ: begin
                if ((ack_s | ~mask_q) == '1) begin
                    state_d  = ACK;
                    ack_up_d = 1'b1;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_d  = RET;
                    req_dn_d = '0;
                end
            end
            RET: begin
                if ((ack_s & mask_q) == '0) begin
                    state_d  = IDLE;
                    ack_up_d = 1'b0;
                    txn_d    = txn_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Watchdog runs only while staying within the waiting states; it never aborts.
        in_wait_q = (state_q == REQ) || (state_q == RET);
        in_wait_d = (state_d == REQ) || (state_d == RET);
        if (in_wait_q && in_wait_d) begin
            wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
        end
        if ((TIMEOUT != 0) && in_wait_d && (wd_d == WD_MAX)) begin
            terr_d = 1'b1;
        end
    end

    assign req_dn      = req_dn_q;
    assign ack_up      = ack_up_q;
    assign txn_count   = txn_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_fork_param_sync.sv
// Scoreboard bench: stimulus queues expected output events, a negedge monitor checks them.
module tb_fork_param_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_up;
    logic        ack_up;
    logic [2:0]  req_dn;
    logic [2:0]  ack_dn;
    logic [2:0]  mask;
    logic        timeout_err;
    logic [15:0] txn_count;

    fork_param_sync #(
        .size        (3),
        .SYNC_STAGES (2),
        .TIMEOUT     (16),
        .CNT_W       (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_up      (req_up),
        .ack_up      (ack_up),
        .req_dn      (req_dn),
        .ack_dn      (ack_dn),
        .mask        (mask),
        .timeout_err (timeout_err),
        .txn_count   (txn_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [2:0]  req_dn;
        logic        ack_up;
        logic        terr;
        logic [15:0] txn;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;
    logic [21:0] last_s;

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic void expect_ev(input int c, input logic [2:0] r, input logic a,
                                      input logic t, input logic [15:0] x);
        exp_t e;
        e.cyc = c; e.req_dn = r; e.ack_up = a; e.terr = t; e.txn = x;
        exp_q.push_back(e);
    endfunction

    task automatic step_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every change on the output bundle consumes one expected event.
    always @(negedge clk) begin
        logic [21:0] cur_s;
        exp_t e;
        if (mon_en) begin
            cur_s = {req_dn, ack_up, timeout_err, txn_count};
            if (cur_s !== last_s) begin
                last_s = cur_s;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_event: cycle %0d req_dn=%b ack_up=%b terr=%b txn=%0d, expected no change",
                             cyc, req_dn, ack_up, timeout_err, txn_count);
                end else begin
                    e = exp_q.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("req_dn", req_dn, e.req_dn);
                    check("ack_up", ack_up, e.ack_up);
                    check("timeout_err", timeout_err, e.terr);
                    check("txn_count", txn_count, e.txn);
                end
            end
        end
    end

    initial begin
        int t0;
        rst    = 1'b0;
        req_up = 1'b0;
        ack_dn = '0;
        mask   = '0;

        // Reset values under random inputs
        repeat (6) begin
            @(posedge clk);
            #1;
            req_up = 1'($urandom);
            ack_dn = 3'($urandom);
            mask   = 3'($urandom);
        end
        #2;
        check("rst_req_dn", req_dn, 0);
        check("rst_ack_up", ack_up, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_txn_count", txn_count, 0);

        req_up = 1'b0;
        ack_dn = '0;
        mask   = '0;
        last_s = '0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        step_to(cyc + 8);

        // Full handshake, staggered acks
        t0 = cyc;
        mask = 3'b111; req_up = 1'b1;
        expect_ev(t0 + 3, 3'b111, 1'b0, 1'b0, 16'd0);
        step_to(t0 + 5);  ack_dn = 3'b001;
        step_to(t0 + 7);  ack_dn = 3'b011;
        step_to(t0 + 9);  ack_dn = 3'b111;
        expect_ev(t0 + 12, 3'b111, 1'b1, 1'b0, 16'd0);
        step_to(t0 + 14); req_up = 1'b0;
        expect_ev(t0 + 17, 3'b000, 1'b1, 1'b0, 16'd0);
        step_to(t0 + 19); ack_dn = 3'b000;
        expect_ev(t0 + 22, 3'b000, 1'b0, 1'b0, 16'd1);
        step_to(t0 + 26);

        // Partial mask; branch 1 acks are ignored
        t0 = cyc;
        mask = 3'b101; req_up = 1'b1;
        expect_ev(t0 + 3, 3'b101, 1'b0, 1'b0, 16'd1);
        step_to(t0 + 5);  ack_dn = 3'b010;
        step_to(t0 + 7);  ack_dn = 3'b000;
        step_to(t0 + 8);  ack_dn = 3'b101;
        expect_ev(t0 + 11, 3'b101, 1'b1, 1'b0, 16'd1);
        step_to(t0 + 13); req_up = 1'b0;
        expect_ev(t0 + 16, 3'b000, 1'b1, 1'b0, 16'd1);
        step_to(t0 + 18); ack_dn = 3'b010;
        expect_ev(t0 + 21, 3'b000, 1'b0, 1'b0, 16'd2);
        step_to(t0 + 23); ack_dn = 3'b000;
        step_to(t0 + 27);

        // Empty mask: REQ passes through in one cycle, req_dn never rises
        t0 = cyc;
        mask = 3'b000; req_up = 1'b1;
        expect_ev(t0 + 4, 3'b000, 1'b1, 1'b0, 16'd2);
        step_to(t0 + 6);  req_up = 1'b0;
        expect_ev(t0 + 10, 3'b000, 1'b0, 1'b0, 16'd3);
        step_to(t0 + 14);

        // Watchdog: branch 2 withheld for 20 cycles in REQ
        t0 = cyc;
        mask = 3'b111; req_up = 1'b1;
        expect_ev(t0 + 3, 3'b111, 1'b0, 1'b0, 16'd3);
        step_to(t0 + 4);  ack_dn = 3'b011;
        expect_ev(t0 + 19, 3'b111, 1'b0, 1'b1, 16'd3);
        step_to(t0 + 23); ack_dn = 3'b111;
        expect_ev(t0 + 26, 3'b111, 1'b1, 1'b1, 16'd3);
        step_to(t0 + 28); req_up = 1'b0;
        expect_ev(t0 + 31, 3'b000, 1'b1, 1'b1, 16'd3);
        step_to(t0 + 33); ack_dn = 3'b000;
        expect_ev(t0 + 36, 3'b000, 1'b0, 1'b1, 16'd4);
        step_to(t0 + 40);

        // Reset in REQ with all acks high
        t0 = cyc;
        req_up = 1'b1;
        expect_ev(t0 + 3, 3'b111, 1'b0, 1'b1, 16'd4);
        step_to(t0 + 5);  ack_dn = 3'b111;
        step_to(t0 + 6);
        expect_ev(t0 + 6, 3'b000, 1'b0, 1'b0, 16'd0);
        rst = 1'b0;
        #1;
        check("midrst_req_dn", req_dn, 0);
        check("midrst_ack_up", ack_up, 0);
        check("midrst_timeout_err", timeout_err, 0);
        check("midrst_txn_count", txn_count, 0);
        step_to(t0 + 8);  rst = 1'b1;
        step_to(t0 + 22);
        t0 = cyc;
        ack_dn = 3'b000;
        expect_ev(t0 + 3, 3'b111, 1'b0, 1'b0, 16'd0);
        step_to(t0 + 5);  ack_dn = 3'b111;
        expect_ev(t0 + 8, 3'b111, 1'b1, 1'b0, 16'd0);
        step_to(t0 + 10); req_up = 1'b0;
        expect_ev(t0 + 13, 3'b000, 1'b1, 1'b0, 16'd0);
        step_to(t0 + 15); ack_dn = 3'b000;
        expect_ev(t0 + 18, 3'b000, 1'b0, 1'b0, 16'd1);
        step_to(t0 + 24);

        check("pending_events", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
